// File: rtl/jtvigil_pkg.sv
// rtl/jtvigil_pkg.sv - shared palette channel encodings and layer-enable bit positions
package jtvigil_pkg;
   typedef enum logic [1:0] {
      CH_R    = 2'd0,
      CH_G    = 2'd1,
      CH_B    = 2'd2,
      CH_NONE = 2'd3
   } pal_ch_e;

   localparam int EN_SCR1 = 0;
   localparam int EN_SCR2 = 1;
   localparam int EN_OBJ  = 3;
endpackage

// File: rtl/jtvigil_colmix_if.sv
// rtl/jtvigil_colmix_if.sv - CPU palette bus between the main CPU and the colour mixer
interface jtvigil_colmix_if;
   logic [10:0] main_addr;
   logic [7:0]  main_dout;
   logic        main_rnw;
   logic        pal_cs;
   logic [7:0]  main_din;

   modport master (output main_addr, main_dout, main_rnw, pal_cs, input main_din);
   modport slave  (input main_addr, main_dout, main_rnw, pal_cs, output main_din);
endinterface

// File: rtl/jtvigil_palbank.sv
// rtl/jtvigil_palbank.sv - 512x5 single-clock dual-port palette bank, read-before-write
module jtvigil_palbank (
   input  logic       clk,
   input  logic       we_a,
   input  logic       re_a,
   input  logic [8:0] addr_a,
   input  logic [4:0] wdata_a,
   output logic [4:0] rdata_a,
   input  logic       re_b,
   input  logic [8:0] addr_b,
   output logic [4:0] rdata_b
);
   logic [4:0] mem [512];
   logic [4:0] rdata_a_q;
   logic [4:0] rdata_b_q;

   // Reads sample the array before this edge's write lands, so a colliding read sees old data.
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wdata_a;
      if (re_a) rdata_a_q <= mem[addr_a];
      if (re_b) rdata_b_q <= mem[addr_b];
   end

   assign rdata_a = rdata_a_q;
   assign rdata_b = rdata_b_q;
endmodule

// File: rtl/jtvigil_colmix.sv
// rtl/jtvigil_colmix.sv - layer priority, palette lookup and blanking for the video output
module jtvigil_colmix
   import jtvigil_pkg::*;
#(
   parameter logic [3:0] PRIO_PAL  = 4'hC,
   parameter logic [3:0] SCR2_BANK = 4'h0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pxl_cen,
   input  logic       lhbl,
   input  logic       lvbl,
   input  logic [7:0] scr1_pxl,
   input  logic [3:0] scr2_pxl,
   input  logic [7:0] obj_pxl,
   input  logic [3:0] gfx_en,
   jtvigil_colmix_if.slave bus,
   output logic [4:0] red,
   output logic [4:0] green,
   output logic [4:0] blue,
   output logic       LHBL_dly,
   output logic       LVBL_dly
);
   logic       scr1_op, scr2_op, obj_op, blk;
   logic [8:0] idx;
   logic       cpu_rd, cpu_wr, blank;
   logic [2:0] pal_we;
   logic [4:0] vid_dat [3];
   logic [4:0] cpu_dat [3];
   logic [7:0] main_din;
   logic       unused_bits;

   logic       black_q, black_d;
   logic       lhbl_s1_q, lhbl_s1_d, lvbl_s1_q, lvbl_s1_d;
   logic [4:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic       lhbl_dly_q, lhbl_dly_d, lvbl_dly_q, lvbl_dly_d;
   pal_ch_e    rd_ch_q, rd_ch_d;

   assign unused_bits = ^{gfx_en[2], bus.main_dout[7:5]};

   assign scr1_op = gfx_en[EN_SCR1] && (scr1_pxl[3:0] != 4'd0);
   assign scr2_op = gfx_en[EN_SCR2] && (scr2_pxl != 4'd0);
   assign obj_op  = gfx_en[EN_OBJ]  && (obj_pxl[3:0] != 4'd0);

   always_comb begin
      idx = 9'd0;
      blk = 1'b0;
      if (scr1_op && (scr1_pxl[7:4] >= PRIO_PAL)) idx = {1'b0, scr1_pxl};
      else if (obj_op)                            idx = {1'b1, obj_pxl};
      else if (scr1_op)                           idx = {1'b0, scr1_pxl};
      else if (scr2_op)                           idx = {1'b1, SCR2_BANK, scr2_pxl};
      else                                        blk = 1'b1;
   end

   assign cpu_rd = bus.pal_cs &  bus.main_rnw;
   assign cpu_wr = bus.pal_cs & ~bus.main_rnw;

   // The banks' video read register is the first pipeline stage: idx is captured there on pxl_cen.
   for (genvar ch = 0; ch < 3; ch++) begin : g_bank
      assign pal_we[ch] = cpu_wr && (bus.main_addr[10:9] == 2'(ch));
      jtvigil_palbank u_bank (
         .clk     (clk),
         .we_a    (pal_we[ch]),
         .re_a    (cpu_rd),
         .addr_a  (bus.main_addr[8:0]),
         .wdata_a (bus.main_dout[4:0]),
         .rdata_a (cpu_dat[ch]),
         .re_b    (pxl_cen),
         .addr_b  (idx),
         .rdata_b (vid_dat[ch])
      );
   end

   always_comb begin
      black_d    = black_q;
      lhbl_s1_d  = lhbl_s1_q;
      lvbl_s1_d  = lvbl_s1_q;
      red_d      = red_q;
      green_d    = green_q;
      blue_d     = blue_q;
      lhbl_dly_d = lhbl_dly_q;
      lvbl_dly_d = lvbl_dly_q;
      rd_ch_d    = cpu_rd ? pal_ch_e'(bus.main_addr[10:9]) : rd_ch_q;
      blank      = black_q | ~lhbl_s1_q | ~lvbl_s1_q;
      if (pxl_cen) begin
         black_d    = blk;
         lhbl_s1_d  = lhbl;
         lvbl_s1_d  = lvbl;
         red_d      = blank ? 5'd0 : vid_dat[0];
         green_d    = blank ? 5'd0 : vid_dat[1];
         blue_d     = blank ? 5'd0 : vid_dat[2];
         lhbl_dly_d = lhbl_s1_q;
         lvbl_dly_d = lvbl_s1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         black_q    <= 1'b0;
         lhbl_s1_q  <= 1'b0;
         lvbl_s1_q  <= 1'b0;
         red_q      <= 5'd0;
         green_q    <= 5'd0;
         blue_q     <= 5'd0;
         lhbl_dly_q <= 1'b0;
         lvbl_dly_q <= 1'b0;
         rd_ch_q    <= CH_NONE;
      end else begin
         black_q    <= black_d;
         lhbl_s1_q  <= lhbl_s1_d;
         lvbl_s1_q  <= lvbl_s1_d;
         red_q      <= red_d;
         green_q    <= green_d;
         blue_q     <= blue_d;
         lhbl_dly_q <= lhbl_dly_d;
         lvbl_dly_q <= lvbl_dly_d;
         rd_ch_q    <= rd_ch_d;
      end
   end

   always_comb begin
      main_din = 8'hFF;
      case (rd_ch_q)
         CH_R:    main_din = {3'b111, cpu_dat[0]};
         CH_G:    main_din = {3'b111, cpu_dat[1]};
         CH_B:    main_din = {3'b111, cpu_dat[2]};
         default: main_din = 8'hFF;
      endcase
   end

   assign bus.main_din = main_din;
   assign red      = red_q;
   assign green    = green_q;
   assign blue     = blue_q;
   assign LHBL_dly = lhbl_dly_q;
   assign LVBL_dly = lvbl_dly_q;
endmodule

// File: tb/tb_jtvigil_colmix.sv
// tb/tb_jtvigil_colmix.sv - randomized bench for jtvigil_colmix against a behavioural mixer model
module tb_jtvigil_colmix;
   localparam logic [3:0] PRIO = 4'hC;
   localparam logic [3:0] BANK2 = 4'h4;

   logic clk, rst, pxl_cen, lhbl, lvbl;
   logic [7:0] scr1_pxl, obj_pxl;
   logic [3:0] scr2_pxl, gfx_en;
   logic [4:0] red, green, blue;
   logic LHBL_dly, LVBL_dly;

   jtvigil_colmix_if bus ();

   jtvigil_colmix #(.PRIO_PAL(PRIO), .SCR2_BANK(BANK2)) dut (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .lhbl(lhbl), .lvbl(lvbl),
      .scr1_pxl(scr1_pxl), .scr2_pxl(scr2_pxl), .obj_pxl(obj_pxl), .gfx_en(gfx_en),
      .bus(bus), .red(red), .green(green), .blue(blue),
      .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit checking = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference palette and display pipeline: what is on screen is the pixel presented two pxl_cen ago.
   logic [4:0]  mpal [3][512];
   logic [14:0] hist_rgb, exp_rgb;
   logic        hist_h, hist_v, exp_h, exp_v;
   logic [7:0]  exp_din;
   int          mk;

   function automatic int ref_index(input logic [7:0] s1, input logic [3:0] s2,
                                    input logic [7:0] ob, input logic [3:0] en);
      bit s1_on = en[0] && (s1 % 16 != 0);
      bit s2_on = en[1] && (s2 != 0);
      bit ob_on = en[3] && (ob % 16 != 0);
      if (s1_on && (s1 / 16) >= PRIO) return int'(s1);
      if (ob_on) return 256 + int'(ob);
      if (s1_on) return int'(s1);
      if (s2_on) return 256 + 16 * int'(BANK2) + int'(s2);
      return -1;
   endfunction

   initial begin
      hist_rgb = 0; exp_rgb = 0; hist_h = 0; hist_v = 0; exp_h = 0; exp_v = 0; exp_din = 8'hFF;
      forever begin
         @(posedge clk);
         if (rst) begin
            hist_rgb = 0; exp_rgb = 0; hist_h = 0; hist_v = 0; exp_h = 0; exp_v = 0; exp_din = 8'hFF;
         end else begin
            if (pxl_cen) begin
               mk = ref_index(scr1_pxl, scr2_pxl, obj_pxl, gfx_en);
               exp_rgb = hist_rgb; exp_h = hist_h; exp_v = hist_v;
               hist_h = lhbl; hist_v = lvbl;
               if (mk < 0 || !lhbl || !lvbl) hist_rgb = 0;
               else hist_rgb = {mpal[0][mk], mpal[1][mk], mpal[2][mk]};
            end
            if (bus.pal_cs && bus.main_rnw)
               exp_din = (bus.main_addr[10:9] == 2'd3) ? 8'hFF
                       : {3'b111, mpal[bus.main_addr[10:9]][bus.main_addr[8:0]]};
            if (bus.pal_cs && !bus.main_rnw && bus.main_addr[10:9] != 2'd3)
               mpal[bus.main_addr[10:9]][bus.main_addr[8:0]] = bus.main_dout[4:0];
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (checking) begin
         chk("rgb", 16'({red, green, blue}), 16'(exp_rgb));
         chk("lhbl_dly", 16'(LHBL_dly), 16'(exp_h));
         chk("lvbl_dly", 16'(LVBL_dly), 16'(exp_v));
         chk("main_din", 16'(bus.main_din), 16'(exp_din));
      end
   end

   task automatic step(input bit cen);
      pxl_cen = cen;
      @(posedge clk);
      #1;
      pxl_cen = 1'b0;
   endtask

   task automatic cpu_wr(input logic [1:0] ch, input logic [8:0] a, input logic [7:0] d);
      bus.pal_cs = 1'b1; bus.main_rnw = 1'b0; bus.main_addr = {ch, a}; bus.main_dout = d;
      step(1'b0);
      bus.pal_cs = 1'b0; bus.main_rnw = 1'b1;
   endtask

   task automatic cpu_rd(input logic [10:0] a);
      bus.pal_cs = 1'b1; bus.main_rnw = 1'b1; bus.main_addr = a;
      step(1'b0);
      bus.pal_cs = 1'b0;
   endtask

   task automatic set_pix(input logic [7:0] s1, input logic [3:0] s2, input logic [7:0] ob,
                          input logic [3:0] en, input logic h, input logic v);
      scr1_pxl = s1; scr2_pxl = s2; obj_pxl = ob; gfx_en = en; lhbl = h; lvbl = v;
   endtask

   logic [3:0] hpat [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
   logic [3:0] dpat [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
   int op;

   initial begin
      rst = 1'b1; pxl_cen = 1'b0;
      set_pix(8'h00, 4'h0, 8'h00, 4'hF, 1'b1, 1'b1);
      bus.pal_cs = 1'b0; bus.main_rnw = 1'b1; bus.main_addr = '0; bus.main_dout = '0;
      step(1'b0);
      checking = 1;
      step(1'b0);
      chk("reset_rgb", 16'({red, green, blue}), 16'h0);
      chk("reset_lhbl", 16'(LHBL_dly), 16'h0);
      chk("reset_din", 16'(bus.main_din), 16'h00FF);
      rst = 1'b0;

      for (int c = 0; c < 3; c++)
         for (int a = 0; a < 512; a++)
            cpu_wr(2'(c), 9'(a), 8'($urandom));

      // Object pixel through a freshly written entry, exactly two pulses late.
      cpu_wr(2'd0, 9'h1C3, 8'h1F); cpu_wr(2'd1, 9'h1C3, 8'h0A); cpu_wr(2'd2, 9'h1C3, 8'h03);
      set_pix(8'h00, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1); step(1'b1);
      set_pix(8'h00, 4'h0, 8'hC3, 4'hF, 1'b1, 1'b1); step(1'b1);
      chk("t1_early", 16'({red, green, blue}), 16'h0);
      set_pix(8'h00, 4'h0, 8'h00, 4'h0, 1'b1, 1'b1); step(1'b1);
      chk("t1_rgb", 16'({red, green, blue}), 16'({5'h1F, 5'h0A, 5'h03}));

      cpu_wr(2'd0, 9'h0D5, 8'h11); cpu_wr(2'd0, 9'h121, 8'h12);
      set_pix(8'hD5, 4'h0, 8'h21, 4'hF, 1'b1, 1'b1); step(1'b1);
      set_pix(8'h35, 4'h0, 8'h21, 4'hF, 1'b1, 1'b1); step(1'b1);
      chk("t2_scr1_over_obj", 16'(red), 16'h11);
      step(1'b1);
      chk("t2_obj_wins", 16'(red), 16'h12);

      set_pix(8'hD5, 4'h7, 8'h21, 4'h0, 1'b1, 1'b1); step(1'b1); step(1'b1);
      chk("t3_all_disabled", 16'({red, green, blue}), 16'h0);
      set_pix(8'hF0, 4'h0, 8'h80, 4'hF, 1'b1, 1'b1); step(1'b1); step(1'b1);
      chk("t3_transparent", 16'({red, green, blue}), 16'h0);
      cpu_wr(2'd0, 9'h147, 8'h0C);
      set_pix(8'h00, 4'h7, 8'h00, 4'b0010, 1'b1, 1'b1); step(1'b1); step(1'b1);
      chk("t3_scr2_bank", 16'(red), 16'h0C);

      set_pix(8'h00, 4'h0, 8'hC3, 4'hF, 1'b1, 1'b1); step(1'b1);
      for (int i = 0; i < 5; i++) begin
         lhbl = hpat[i][0];
         step(1'b1);
         chk("t4_lhbl_dly", 16'(LHBL_dly), 16'(dpat[i]));
         chk("t4_red", 16'(red), dpat[i][0] ? 16'h1F : 16'h0);
      end

      cpu_wr(2'd0, 9'h055, 8'h05);
      set_pix(8'h55, 4'h0, 8'h00, 4'hF, 1'b1, 1'b1); step(1'b1);
      bus.pal_cs = 1'b1; bus.main_rnw = 1'b0; bus.main_addr = {2'd0, 9'h055}; bus.main_dout = 8'h1A;
      step(1'b1);
      bus.pal_cs = 1'b0; bus.main_rnw = 1'b1;
      step(1'b1);
      chk("t5_collision_old", 16'(red), 16'h05);
      step(1'b1);
      chk("t5_next_new", 16'(red), 16'h1A);
      cpu_rd(11'h655);
      chk("t5_ch3_read", 16'(bus.main_din), 16'h00FF);
      cpu_rd({2'd0, 9'h055});
      chk("t5_r_read", 16'(bus.main_din), 16'h00FA);
      step(1'b0);
      chk("t5_read_holds", 16'(bus.main_din), 16'h00FA);

      set_pix(8'h00, 4'h0, 8'hC3, 4'hF, 1'b1, 1'b1); step(1'b1); step(1'b1);
      chk("t6_before", 16'(red), 16'h1F);
      rst = 1'b1; step(1'b0); rst = 1'b0;
      chk("t6_rgb_now", 16'({red, green, blue}), 16'h0);
      chk("t6_blank_now", 16'({LHBL_dly, LVBL_dly}), 16'h0);
      step(1'b1);
      chk("t6_one_pulse", 16'({red, green, blue}), 16'h0);
      step(1'b1);
      chk("t6_intact", 16'({red, green, blue}), 16'({5'h1F, 5'h0A, 5'h03}));

      for (int n = 0; n < 5000; n++) begin
         scr1_pxl = 8'($urandom);
         if ($urandom_range(3) == 0) scr1_pxl[3:0] = 4'h0;
         obj_pxl = 8'($urandom);
         if ($urandom_range(3) == 0) obj_pxl[3:0] = 4'h0;
         scr2_pxl = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
         gfx_en = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
         lhbl = ($urandom_range(9) != 0);
         lvbl = ($urandom_range(19) != 0);
         rst = ($urandom_range(499) == 0);
         op = int'($urandom_range(3));
         bus.pal_cs = !rst && op < 2;
         bus.main_rnw = (op == 1);
         bus.main_addr = 11'($urandom);
         bus.main_dout = 8'($urandom);
         step($urandom_range(2) == 0);
      end
      rst = 1'b0; bus.pal_cs = 1'b0;
      step(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
